// File: rtl/code_lock_if.sv
// code_lock_if: groups the code lock's button inputs and status outputs into one bundle.
// Latency: none; wires only.
// Backpressure: none; buttons are raw levels and the status outputs are continuously valid.
// Signals: btn_next/btn_enter (raw asynchronous buttons), digit, digit_idx, unlocked, alarm.
// The master modport drives the buttons. The slave modport (the lock) drives the status.
`timescale 1ns/1ps
interface code_lock_if #(
  parameter int DIGIT_W = 4
);
  logic               btn_next;
  logic               btn_enter;
  logic [DIGIT_W-1:0] digit;
  logic [2:0]         digit_idx;
  logic               unlocked;
  logic               alarm;

  modport master (
    output btn_next, btn_enter,
    input  digit, digit_idx, unlocked, alarm
  );

  modport slave (
    input  btn_next, btn_enter,
    output digit, digit_idx, unlocked, alarm
  );
endinterface

// File: rtl/code_lock.sv
// code_lock: digit-by-digit combination lock with a fail counter and a timed lockout.
// Latency: a press reaches the FSM 3 edges after first sampling (DEBOUNCE_CYC+3 with debounce).
// Backpressure: none. Presses during LOCKOUT are dropped, and so are next presses in OPEN.
// Ports: clk, rst_n (asynchronous, active low), bus (code_lock_if.slave).
//   The bus carries btn_next/btn_enter in, and digit/digit_idx/unlocked/alarm out.
// Build option: define CODE_LOCK_DEBOUNCE_EN to insert a DEBOUNCE_CYC stability filter per button.
`timescale 1ns/1ps
module code_lock #(
  parameter int DIGIT_W      = 4,
  parameter int NUM_DIGITS   = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] CODE = 16'h1234,
  parameter int MAX_FAILS    = 3,
  parameter int LOCKOUT_CYC  = 1000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  code_lock_if.slave  bus
);

  localparam int TOT = DIGIT_W * NUM_DIGITS;
  localparam int FW  = $clog2(MAX_FAILS + 1);
  localparam int LW  = $clog2(LOCKOUT_CYC + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------
  // Button conditioning. Bit 0 is btn_next and bit 1 is btn_enter.
  // ---------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] meta_q, sync_q;
  logic [1:0] vld_q;     // becomes all-ones once sync_q holds real samples after reset
  logic [1:0] arm_q;     // set once a button has been seen released after reset
  logic [1:0] prev_q;
  logic [1:0] lvl;
  logic [1:0] pulse;

  assign btn_raw = {bus.btn_enter, bus.btn_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      vld_q  <= {vld_q[0], 1'b1};
    end
  end

`ifdef CODE_LOCK_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]     db_q;
  logic [DBW-1:0] db_cnt_q [2];

  // The filtered level follows sync_q only after sync_q has differed from it
  // for DEBOUNCE_CYC consecutive samples. Any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYC - 1)) begin
          db_q[i]     <= sync_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = db_q;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYC;
  assign lvl = sync_q;
`endif

  // Reset clears the synchronisers, so a button held through reset would look
  // like a fresh rising edge. A button may only fire after it has been seen low
  // on a real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q  <= '0;
      prev_q <= '0;
    end else begin
      arm_q  <= arm_q | ({2{vld_q[1]}} & ~sync_q);
      prev_q <= lvl;
    end
  end

  assign pulse = lvl & ~prev_q & arm_q;

  logic next_p, enter_p;
  assign next_p  = pulse[0];
  assign enter_p = pulse[1];

  // ---------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_t;

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [2:0]         idx_q, idx_d;
  logic [TOT-1:0]     entry_q, entry_d;
  logic [FW-1:0]      fail_q, fail_d;
  logic [LW-1:0]      lock_q, lock_d;
  logic               unlocked_q, alarm_q;
  logic [TOT-1:0]     full_code;

  // The entry register with the digit being dialled appended in the LS position.
  // This is both the next entry value and the complete code on the last digit.
  assign full_code = (entry_q << DIGIT_W) | TOT'(digit_q);

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    case (state_q)
      ST_ENTRY: begin
        // Enter wins over a simultaneous next.
        if (enter_p) begin
          digit_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            entry_d = '0;
            if (full_code == CODE) begin
              state_d = ST_OPEN;
              fail_d  = '0;
            end else if (fail_q == FW'(MAX_FAILS - 1)) begin
              state_d = ST_LOCKOUT;
              fail_d  = '0;
              lock_d  = LW'(LOCKOUT_CYC - 1);
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end else begin
            entry_d = full_code;
            idx_d   = idx_q + 1'b1;
          end
        end else if (next_p) begin
          digit_d = digit_q + 1'b1;
        end
      end
      ST_OPEN: begin
        if (enter_p) begin
          state_d = ST_ENTRY;
          digit_d = '0;
          idx_d   = '0;
          entry_d = '0;
        end
      end
      ST_LOCKOUT: begin
        // lock_q counts LOCKOUT_CYC-1 down to 0, so the state lasts LOCKOUT_CYC cycles.
        if (lock_q == '0) state_d = ST_ENTRY;
        else              lock_d  = lock_q - 1'b1;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      digit_q    <= '0;
      idx_q      <= '0;
      entry_q    <= '0;
      fail_q     <= '0;
      lock_q     <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      fail_q     <= fail_d;
      lock_q     <= lock_d;
      // Decoded from the next state, so the flags track state_q cycle for cycle.
      unlocked_q <= (state_d == ST_OPEN);
      alarm_q    <= (state_d == ST_LOCKOUT);
    end
  end

  assign bus.digit     = digit_q;
  assign bus.digit_idx = idx_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: scoreboard bench for code_lock. The bench keeps a reference model.
// On each button release the model's expected outputs are queued; they are popped once the DUT has settled.
`timescale 1ns/1ps
module tb_code_lock;
  localparam int DIGIT_W      = 4;
  localparam int NUM_DIGITS   = 4;
  localparam int MAX_FAILS    = 3;
  localparam int LOCKOUT_CYC  = 1000;
  localparam int DEBOUNCE_CYC = 16;
`ifdef CODE_LOCK_DEBOUNCE_EN
  localparam int LAT = DEBOUNCE_CYC + 3;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  code_lock_if #(.DIGIT_W(DIGIT_W)) bus ();

  code_lock #(
    .DIGIT_W(DIGIT_W), .NUM_DIGITS(NUM_DIGITS), .CODE(16'h1234),
    .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYC(LOCKOUT_CYC), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_ENTRY, M_OPEN, M_LOCK} mst_t;
  typedef struct packed {
    logic       unl;
    logic       alm;
    logic [2:0] idx;
    logic [3:0] dig;
  } obs_t;

  mst_t        m_st = M_ENTRY;
  int          m_dig = 0;
  int          m_idx = 0;
  int          m_fail = 0;
  logic [15:0] m_entry = '0;
  obs_t        exp_q[$];

  task automatic m_reset();
    m_st = M_ENTRY; m_dig = 0; m_idx = 0; m_fail = 0; m_entry = '0;
  endtask

  task automatic m_next();
    if (m_st == M_ENTRY) m_dig = (m_dig + 1) % 16;
  endtask

  task automatic m_enter();
    logic [15:0] full;
    case (m_st)
      M_ENTRY: begin
        full = {m_entry[11:0], 4'(m_dig)};
        m_dig = 0;
        if (m_idx < NUM_DIGITS - 1) begin
          m_entry = full;
          m_idx++;
        end else begin
          m_idx = 0;
          m_entry = '0;
          if (full == 16'h1234) begin
            m_st = M_OPEN;
            m_fail = 0;
          end else begin
            m_fail++;
            if (m_fail == MAX_FAILS) begin
              m_st = M_LOCK;
              m_fail = 0;
            end
          end
        end
      end
      M_OPEN: begin
        m_st = M_ENTRY; m_dig = 0; m_idx = 0; m_entry = '0;
      end
      default: ;
    endcase
  endtask

  task automatic push_exp();
    obs_t o;
    o.unl = (m_st == M_OPEN);
    o.alm = (m_st == M_LOCK);
    o.idx = 3'(m_idx);
    o.dig = 4'(m_dig);
    exp_q.push_back(o);
  endtask

  task automatic pop_check(input string tag);
    obs_t o;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({tag, "_unlocked"},  32'(bus.unlocked),  32'(o.unl));
      chk({tag, "_alarm"},     32'(bus.alarm),     32'(o.alm));
      chk({tag, "_digit_idx"}, 32'(bus.digit_idx), 32'(o.idx));
      chk({tag, "_digit"},     32'(bus.digit),     32'(o.dig));
    end
  endtask

  // Press and release, then compare once the DUT has had time to act.
  task automatic press(input bit nxt, input bit ent, input int hold, input string tag);
    @(negedge clk);
    bus.btn_next  = nxt;
    bus.btn_enter = ent;
    repeat (hold) @(negedge clk);
    bus.btn_next  = 1'b0;
    bus.btn_enter = 1'b0;
    if (ent)      m_enter();
    else if (nxt) m_next();
    push_exp();
    repeat (HOLD) @(negedge clk);
    pop_check(tag);
  endtask

  task automatic enter_code(input logic [15:0] code, input string tag);
    logic [3:0] d;
    for (int i = 3; i >= 0; i--) begin
      d = code[i*4 +: 4];
      repeat (d) press(1'b1, 1'b0, HOLD, {tag, "_dial"});
      press(1'b0, 1'b1, HOLD, {tag, "_commit"});
    end
  endtask

  // Length of the most recent completed alarm interval.
  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (bus.alarm) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    bus.btn_next  = 1'b0;
    bus.btn_enter = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_unlocked",  32'(bus.unlocked),  32'd0);
    chk("rst_alarm",     32'(bus.alarm),     32'd0);
    chk("rst_digit",     32'(bus.digit),     32'd0);
    chk("rst_digit_idx", 32'(bus.digit_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First next press: digit must change exactly LAT edges after first sampling.
    bus.btn_next = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lat_before", 32'(bus.digit), 32'd0);
    @(posedge clk);
    #1 chk("lat_at", 32'(bus.digit), 32'd1);
    @(negedge clk);
    bus.btn_next = 1'b0;
    m_next();
    push_exp();
    repeat (HOLD) @(negedge clk);
    pop_check("lat_done");

    // Complete 1-2-3-4 and open.
    press(1'b0, 1'b1, HOLD, "d1_commit");
    repeat (2) press(1'b1, 1'b0, HOLD, "d2_dial");
    press(1'b0, 1'b1, HOLD, "d2_commit");
    repeat (3) press(1'b1, 1'b0, HOLD, "d3_dial");
    press(1'b0, 1'b1, HOLD, "d3_commit");
    repeat (4) press(1'b1, 1'b0, HOLD, "d4_dial");
    press(1'b0, 1'b1, HOLD, "open");

    // Next is ignored in OPEN; enter relocks.
    press(1'b1, 1'b0, HOLD, "open_next_ignored");
    press(1'b0, 1'b1, HOLD, "relock");

    // 17 nexts wrap to 1; one of them is held 40 cycles and must count once.
    press(1'b1, 1'b0, 40, "long_hold");
    repeat (16) press(1'b1, 1'b0, HOLD, "wrap_dial");
    // Simultaneous next+enter acts as enter: digit 1 is stored unchanged.
    press(1'b1, 1'b1, HOLD, "simul");
    repeat (2) press(1'b1, 1'b0, HOLD, "s2_dial");
    press(1'b0, 1'b1, HOLD, "s2_commit");
    repeat (3) press(1'b1, 1'b0, HOLD, "s3_dial");
    press(1'b0, 1'b1, HOLD, "s3_commit");
    repeat (4) press(1'b1, 1'b0, HOLD, "s4_dial");
    press(1'b0, 1'b1, HOLD, "simul_open");
    press(1'b0, 1'b1, HOLD, "relock2");

    // Two wrong codes, then the right one clears the fail count.
    enter_code(16'h0000, "wrong1");
    enter_code(16'h0000, "wrong2");
    enter_code(16'h1234, "right");
    press(1'b0, 1'b1, HOLD, "relock3");
    enter_code(16'h0000, "wrong3");
    enter_code(16'h0000, "wrong4");
    chk("no_early_lockout", 32'(bus.alarm), 32'd0);
    // Third consecutive miss: lockout.
    enter_code(16'h0000, "wrong5");

    // Buttons are ignored during lockout.
    press(1'b1, 1'b0, HOLD, "lock_next");
    press(1'b0, 1'b1, HOLD, "lock_enter");
    guard = 0;
    while (bus.alarm && guard < 3 * LOCKOUT_CYC) begin
      @(negedge clk);
      guard++;
    end
    chk("lock_end", 32'(bus.alarm), 32'd0);
    @(negedge clk);
    #1 chk("lock_len", 32'(last_run), 32'(LOCKOUT_CYC));
    m_st = M_ENTRY;
    push_exp();
    pop_check("post_lock");

    // Reset in OPEN with enter held: no pulse until released and re-pressed.
    enter_code(16'h1234, "open_again");
    @(negedge clk);
    bus.btn_enter = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_open_unlocked", 32'(bus.unlocked), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (20) @(negedge clk);
    push_exp();
    pop_check("held_through_rst");
    bus.btn_enter = 1'b0;
    repeat (HOLD) @(negedge clk);
    push_exp();
    pop_check("held_released");
    press(1'b0, 1'b1, HOLD, "repress");

`ifdef CODE_LOCK_DEBOUNCE_EN
    // Bounces shorter than DEBOUNCE_CYC must be rejected.
    repeat (3) begin
      @(negedge clk);
      bus.btn_next = 1'b1;
      repeat (10) @(negedge clk);
      bus.btn_next = 1'b0;
      repeat (10) @(negedge clk);
    end
    push_exp();
    pop_check("bounce");
    bus.btn_next = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("db_before", 32'(bus.digit), 32'(m_dig));
    @(posedge clk);
    #1 chk("db_at", 32'(bus.digit), 32'((m_dig + 1) % 16));
    repeat (40 - LAT) @(negedge clk);
    bus.btn_next = 1'b0;
    m_next();
    push_exp();
    repeat (HOLD) @(negedge clk);
    pop_check("db_held");
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/code_lock.md
CODE_LOCK -- requirements
Module: code_lock

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, bits per code digit.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, digits per code (1..8).
REQ-003 SHALL have parameter CODE, default 16'h1234, secret code of width DIGIT_W*NUM_DIGITS, first-entered digit in the MS position.
REQ-004 SHALL have parameter MAX_FAILS, default 3, consecutive wrong codes before lockout (>=1).
REQ-005 SHALL have parameter LOCKOUT_CYC, default 1000, lockout duration in clk cycles (>=1).
REQ-006 SHALL have parameter DEBOUNCE_CYC, default 16, required stable cycles per button (>=1).
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 btn_next  input  1  raw asynchronous active-high button, increments current digit.
REQ-010 btn_enter  input  1  raw asynchronous active-high button, commits current digit / relocks.
REQ-011 digit  output  DIGIT_W  value of digit currently being dialled.
REQ-012 digit_idx  output  3  index of digit being dialled, 0..NUM_DIGITS-1.
REQ-013 unlocked  output  1  high while in OPEN.
REQ-014 alarm  output  1  high while in LOCKOUT.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, optional debounce (REQ-031), then a rising-edge detector producing a one-cycle internal pulse per press.
REQ-016 FSM SHALL have states ENTRY, OPEN, LOCKOUT; reset state ENTRY.
REQ-017 ENTRY, next pulse: digit SHALL increment by 1 modulo 2^DIGIT_W on the following edge (max wraps to 0).
REQ-018 ENTRY, enter pulse with digit_idx < NUM_DIGITS-1: digit SHALL be shifted into the entry register, digit_idx incremented, digit cleared to 0.
REQ-019 ENTRY, enter pulse with digit_idx = NUM_DIGITS-1: full entry SHALL be compared with CODE on that edge; digit and digit_idx cleared to 0.
REQ-020 Match SHALL go to OPEN and clear the fail counter; mismatch SHALL increment the fail counter and stay in ENTRY.
REQ-021 Mismatch making fail counter equal MAX_FAILS SHALL go to LOCKOUT, clear the fail counter, and load the lockout counter with LOCKOUT_CYC-1.
REQ-022 LOCKOUT: both pulses SHALL be ignored; counter decrements each cycle; at 0 SHALL go to ENTRY, so alarm is high exactly LOCKOUT_CYC cycles.
REQ-023 OPEN: next pulses SHALL be ignored; enter pulse SHALL go to ENTRY with digit, digit_idx, entry register cleared.
REQ-024 Simultaneous next and enter pulses SHALL act as enter only; the next press is dropped.
REQ-025 A held button SHALL yield exactly one pulse; another requires release then re-press.
REQ-026 Button pulses arriving during the state-change cycle SHALL be evaluated in the new state on the next edge, never lost or double-applied.
REQ-027 unlocked and alarm SHALL be registered, decoded from state, never both high.

Reset
REQ-028 rst_n low SHALL asynchronously force ENTRY, digit=0, digit_idx=0, unlocked=0, alarm=0, fail counter, lockout counter, entry register, synchronisers, debouncers and edge detectors to 0.
REQ-029 Reset mid-entry, in OPEN or LOCKOUT SHALL discard all progress; a button held through reset release SHALL NOT generate a pulse until released and re-pressed.
REQ-030 Reset deassertion is synchronous to clk externally; no internal reset synchroniser.

Configuration
REQ-031 With CODE_LOCK_DEBOUNCE_EN defined, debounced level SHALL change only after the synchronised input holds the new value for DEBOUNCE_CYC consecutive cycles; digit updates DEBOUNCE_CYC+3 edges after btn_next first sampled high.
REQ-032 Without CODE_LOCK_DEBOUNCE_EN, debounce counters SHALL be absent, synchroniser output feeds the edge detector directly, and digit updates 3 edges after btn_next first sampled high; DEBOUNCE_CYC ignored.

Verification
REQ-033 Defaults, debounce off: press next 1x, enter, 2x, enter, 3x, enter, 4x, enter -> unlocked=1 the edge after last enter pulse, digit_idx=0.
REQ-034 Defaults: enter 0000 three times -> alarm=1 after third, exactly 1000 cycles, buttons ignored, then ENTRY with digit=0.
REQ-035 DIGIT_W=4: 17 next presses -> digit=1 (wrap); next and enter same cycle on digit_idx=0 -> digit_idx=1, entered digit unchanged.
REQ-036 Debounce on, DEBOUNCE_CYC=16: btn_next bouncing 10-cycle pulses -> digit unchanged; held 40 cycles -> digit+1 once, at edge 19.
REQ-037 Assert rst_n low in OPEN with btn_enter held, release -> all outputs 0, no pulse until btn_enter released and re-pressed.
REQ-038 Two wrong codes then correct -> OPEN, fail counter 0; further two wrong codes do not trigger lockout.
